// File: rtl/portal_pipe_arbiter.sv
// portal_pipe_arbiter: round-robin, burst-bounded arbiter sharing one portal
// pipe between two message serializers, with a one-entry registered output
// stage and per-source accepted-beat counters.
//
// Ports:
//   CLK, nRST                          clock, synchronous active-low reset
//   in0_enq__ENA/_v/__RDY, in0_req     source 0 enq method and request level
//   in1_enq__ENA/_v/__RDY, in1_req     source 1 enq method and request level
//   out_enq__ENA/_v/_src               output beat valid, payload, source ID
//   out_enq__RDY                       pipe accepts the output beat
//   beats0, beats1                     accepted-beat counters (wrap at 2^16)
module portal_pipe_arbiter #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in0_enq__ENA,
  input  logic [WIDTH-1:0] in0_enq_v,
  output logic             in0_enq__RDY,
  input  logic             in0_req,
  input  logic             in1_enq__ENA,
  input  logic [WIDTH-1:0] in1_enq_v,
  output logic             in1_enq__RDY,
  input  logic             in1_req,
  output logic             out_enq__ENA,
  output logic [WIDTH-1:0] out_enq_v,
  output logic             out_enq_src,
  input  logic             out_enq__RDY,
  output logic [15:0]      beats0,
  output logic [15:0]      beats1
);

  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      beats0_q, beats0_d;
  logic [15:0]      beats1_q, beats1_d;

  logic             space;
  logic             grant_vld;
  logic             grant_id;
  logic             acc0, acc1, acc;
  logic [CNT_W-1:0] cnt_inc;

  // Grant: a lone requester wins; under contention the priority owner wins.
  always_comb begin
    space     = !full_q | out_enq__RDY;
    grant_vld = in0_req | in1_req;
    grant_id  = (in0_req & in1_req) ? ptr_q : in1_req;
    in0_enq__RDY = nRST & space & grant_vld & !grant_id;
    in1_enq__RDY = nRST & space & grant_vld &  grant_id;
    // ENA without RDY is ignored.
    acc0 = in0_enq__ENA & in0_enq__RDY;
    acc1 = in1_enq__ENA & in1_enq__RDY;
    acc  = acc0 | acc1;
  end

  // Next state for output stage, burst tracking and counters.
  always_comb begin
    full_d   = full_q;
    data_d   = data_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    beats0_d = beats0_q + 16'(acc0);
    beats1_d = beats1_q + 16'(acc1);

    if (full_q && out_enq__RDY) full_d = 1'b0;

    if (acc) begin
      full_d = 1'b1;
      data_d = acc1 ? in1_enq_v : in0_enq_v;
      src_d  = acc1;
      if (acc1 == ptr_q) begin
        if (cnt_inc == BURST_LAST) begin
          ptr_d = ~ptr_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (MAX_BURST == 1) begin
        // A single-beat burst hands priority straight back.
        ptr_d = ~acc1;
        cnt_d = '0;
      end else begin
        ptr_d = acc1;
        cnt_d = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full_q   <= 1'b0;
      data_q   <= '0;
      src_q    <= 1'b0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      beats0_q <= '0;
      beats1_q <= '0;
    end else begin
      full_q   <= full_d;
      data_q   <= data_d;
      src_q    <= src_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      beats0_q <= beats0_d;
      beats1_q <= beats1_d;
    end
  end

  assign out_enq__ENA = full_q;
  assign out_enq_v    = data_q;
  assign out_enq_src  = src_q;
  assign beats0       = beats0_q;
  assign beats1       = beats1_q;

endmodule

// File: doc/portal_pipe_arbiter.md
# portal_pipe_arbiter

Shares one 96-bit portal pipe (`enq` method) between two message serializers, for example a request-output and an indication-output stream bound for the same transport. Arbitration is round-robin with a bounded burst length, so a multi-beat message stays contiguous while neither source can starve the other. A one-entry registered output stage carries each beat to the pipe together with the ID of the source that produced it. Per-source beat counters are exposed for debug.

## Interface
- `WIDTH`, 96: pipe payload width in bits.
- `MAX_BURST`, 4: maximum consecutive beats granted to the priority owner while the other source is waiting; legal range 1..15.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, synchronous, active-low.
- `in0$enq__ENA` in 1: source 0 beat transfer; asserted only while `in0$enq__RDY` is high.
- `in0$enq$v` in `WIDTH`: source 0 payload.
- `in0$enq__RDY` out 1: source 0 may transfer this cycle.
- `in0$req` in 1: source 0 has a beat waiting; this is a level and is independent of RDY.
- `in1$enq__ENA`, `in1$enq$v`, `in1$enq__RDY`, `in1$req`: same as the source 0 ports, for source 1.
- `out$enq__ENA` out 1: output beat valid.
- `out$enq$v` out `WIDTH`: output payload.
- `out$enq$src` out 1: source ID of the current output beat.
- `out$enq__RDY` in 1: the pipe accepts the beat.
- `beats0`, `beats1` out 16: accepted-beat counters, one per source.

## Operation
- **State:**
  - `full` (output stage occupied), `data[WIDTH-1:0]`, `src`.
  - `ptr`: priority owner, 1 bit.
  - `cnt`: beats granted in the current burst, 4 bits.
  - `beats0`, `beats1`.
- **Reset values:** all state is 0. Therefore `out$enq__ENA`=0, `out$enq$v`=0, `out$enq$src`=0, both `__RDY`=0 while `nRST` is low, and `beats0`=`beats1`=0.
- **Space:** `space = !full | out$enq__RDY`.
- **Grant, combinational:**
  - If only `ink$req` is high, grant k.
  - If both are high, grant `ptr`.
  - If neither is high, grant nothing.
  - `ink$enq__RDY = nRST & space & grant==k`. At most one RDY is high in any cycle.
- **Accept from source k** (`ink$enq__ENA`):
  - Next cycle: `data`<=`ink$enq$v`, `src`<=k, `full`<=1.
  - `beatsk` increments modulo 2^16 (0xFFFF wraps to 0x0000).
- **Drain:**
  - `out$enq__ENA = full`; `out$enq$v = data`; `out$enq$src = src`.
  - If `full & out$enq__RDY` and no accept occurs that cycle, `full`<=0.
  - Drain and accept in the same cycle gives back-to-back beats, and `full` stays 1.
- **Pointer and burst update**, on an accepted beat from k only:
  - If k==`ptr`: `cnt`<=`cnt`+1. When `cnt`+1==`MAX_BURST`, `ptr`<=~`ptr` and `cnt`<=0.
  - If k!=`ptr` (owner was not requesting): `ptr`<=k and `cnt`<=1. If `MAX_BURST`==1, instead `ptr`<=~k and `cnt`<=0.
  - With no accept, `ptr` and `cnt` hold.
- **ENA protocol:**
  - ENA without RDY is a protocol violation; the bench asserts on it and the RTL ignores it (no state change).
  - `ink$req` low together with ENA high is also a violation.
- **Reset mid-operation:** a buffered beat is discarded, `full`=0, the pointer returns to source 0, and the counters clear.

## Timing
- Input-to-output latency is 1 cycle: accept in cycle N gives `out$enq__ENA`=1 in cycle N+1.
- Throughput is 1 beat/cycle sustained while `out$enq__RDY` is held high.
- `ink$enq__RDY` depends combinationally on `out$enq__RDY`, `in0$req`, `in1$req` and state. There is no combinational path from ENA to RDY.
- Output payload and src are stable while `full & !out$enq__RDY`.
- First grant after reset release: the cycle after `nRST` rises, RDY may go high.

## Test plan
- **Single source:** `in0$req`=1 streams A0..A7, `out$enq__RDY`=1 → out carries A0..A7 on consecutive cycles, src=0, one-cycle latency, `beats0`=8.
- **Contention, MAX_BURST=4:** both sources request continuously with RDY=1 → src sequence 0,0,0,0,1,1,1,1,0,...; `beats0`=`beats1` after every 8 beats.
- **Alternation, MAX_BURST=1:** both sources requesting → src alternates 0,1,0,1; a single source still achieves 1 beat/cycle.
- **Backpressure:** `out$enq__RDY`=0 for 5 cycles with the stage full → out beat held stable, both input RDYs low. On RDY=1 the beat drains and the next beat is accepted in the same cycle.
- **Reset mid-burst:** `nRST` low after 2 beats of a source-1 burst with `full`=1 → next cycle `out$enq__ENA`=0, counters 0. After release, simultaneous requests grant source 0 first.
- **Counter wrap:** 65537 beats from source 1 → `beats1`=1, `beats0`=0.
